pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV64I pipeline (IF/ID/EX/MEM/WB). It compares decode-stage register reads against in-flight writes and produces forwarding selects, load-use stalls, branch/jump flushes and memory-wait freezes. It also drains and halts the pipeline on the termination instruction (opcode 0x6b). All pipeline registers take their stall/flush controls from this block only.

Parameters:
DRAIN_CYCLES, 3, cycles after the termination instruction leaves EX before `halted` asserts (lets it reach WB).
ADDR_W, 5, register-file address width.

Ports:
clk  input  1  pipeline clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
id_rs1_r_ena  input  1  ID reads rs1.
id_rs1_r_addr  input  5  ID rs1 address.
id_rs2_r_ena  input  1  ID reads rs2.
id_rs2_r_addr  input  5  ID rs2 address.
ex_rd_w_ena  input  1  EX instruction writes rd.
ex_rd_w_addr  input  5  EX rd.
ex_mem_rd_ena  input  1  EX instruction is a load.
ex_bj_taken  input  1  EX branch taken, or JAL/JALR.
ex_term  input  1  EX holds the termination instruction.
mem_rd_w_ena  input  1  MEM instruction writes rd.
mem_rd_w_addr  input  5  MEM rd.
mem_req  input  1  MEM stage issues a data-memory access.
mem_ready  input  1  data memory completes the access this cycle.
if_ready  input  1  instruction fetch has a valid instruction this cycle.
fwd_rs1_sel  output  2  0 = regfile, 1 = EX result, 2 = MEM result.
fwd_rs2_sel  output  2  same encoding, for rs2.
pc_stall  output  1  hold PC.
if_id_stall  output  1  hold the IF/ID register.
if_id_flush  output  1  load a bubble into IF/ID.
id_ex_stall  output  1  hold the ID/EX register.
id_ex_flush  output  1  load a bubble into ID/EX.
ex_mem_stall  output  1  hold the EX/MEM register.
mem_wb_flush  output  1  load a bubble into MEM/WB.
pc_redirect  output  1  PC takes the EX target.
halted  output  1  pipeline stopped.

Behaviour:
- Reset (rst=0, async): state=RUN, drain counter=0. All outputs 0 while rst=0.
- Forwarding (combinational, every state):
  - rs1 selects 1 if id_rs1_r_ena & ex_rd_w_ena & ex_rd_w_addr==id_rs1_r_addr & addr!=0 & ~ex_mem_rd_ena.
  - Otherwise rs1 selects 2 if the same test passes against the MEM fields.
  - Otherwise rs1 selects 0. rs2 uses the same rules.
  - EX match takes priority over MEM match. Address x0 never forwards.
- Hazard terms:
  - load_use = ex_mem_rd_ena & ex_rd_w_ena & ex_rd!=0 & (rs1 or rs2 enabled-match ex_rd).
  - memwait = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, DRAIN, HALT.
- RUN, priority order:
  1. memwait: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush all 1. Branch/term outputs are suppressed. Next state MEM_WAIT.
  2. ex_bj_taken: pc_redirect=1, if_id_flush=1, id_ex_flush=1. Overrides load_use and if_ready.
  3. ex_term: if_id_flush=1, id_ex_flush=1, pc_stall=1. Next state DRAIN with counter=DRAIN_CYCLES-1.
  4. load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1, for exactly one cycle.
  5. ~if_ready: pc_stall=1, if_id_flush=1.
- MEM_WAIT:
  - While mem_ready=0: freeze outputs as in RUN case 1.
  - The cycle mem_ready=1: stalls drop, and RUN rules (2..5) are evaluated on the current inputs. Next state RUN.
- DRAIN:
  - pc_stall=1, if_id_flush=1, id_ex_flush=1.
  - memwait freezes the pipeline and also freezes the counter.
  - Counter decrements each non-frozen cycle. At 0, next state HALT.
- HALT: halted=1; pc_stall, if_id_stall, id_ex_stall and ex_mem_stall all 1; mem_wb_flush=1. Sticky until reset.
- Reset mid-MEM_WAIT or mid-DRAIN returns to RUN immediately.

Optional Feature:
PIPE_CTRL_PERF_EN:
- When defined, adds output ports perf_stall_cyc (64), perf_flush_cnt (64) and perf_lu_cnt (64). They count, respectively:
  - cycles with pc_stall=1 in RUN or MEM_WAIT;
  - cycles with pc_redirect=1;
  - load-use bubbles.
- All three counters reset to 0 asynchronously, wrap at 2^64 and freeze in HALT.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- EX writes x5 (non-load), ID reads rs1=x5, rs2=x5 -> fwd_rs1_sel=1, fwd_rs2_sel=1, no stall. Repeat with rd=x0 -> both sels 0.
- EX is a load to x7, ID reads rs2=x7 -> one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Next cycle (load now in MEM) -> fwd_rs2_sel=2, no stall.
- ex_bj_taken=1 coinciding with load_use and if_ready=0 -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_stall=0.
- mem_req=1, mem_ready=0 for 4 cycles with ex_bj_taken=1 -> all stalls 1 and pc_redirect=0 for 4 cycles. On the mem_ready=1 cycle -> pc_redirect=1, then state RUN.
- ex_term=1 in RUN, no memwait -> halted rises exactly 3 cycles after DRAIN is entered and stays 1. rst=0 pulse -> halted=0 immediately.
- With PIPE_CTRL_PERF_EN, 2 load-use events and 1 redirect -> perf_lu_cnt=2, perf_flush_cnt=1.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: bundle of pipeline hazard inputs and stall/flush controls
// exchanged between the pipeline datapath and the pipe_ctrl controller.
//
// Modports:
//   master - the controller: reads decode/EX/MEM/fetch status and
//            drives forwarding selects, stall/flush/redirect and halted.
//   slave  - the pipeline datapath: the mirror image of master.
//
// Signals (datapath -> controller):
//   id_rs1_r_ena/addr, id_rs2_r_ena/addr : decode-stage register reads
//   ex_rd_w_ena/addr, ex_mem_rd_ena      : EX write-back target, EX is a load
//   ex_bj_taken, ex_term                 : EX branch/jump taken, termination op
//   mem_rd_w_ena/addr                    : MEM write-back target
//   mem_req, mem_ready                   : data-memory handshake
//   if_ready                             : fetch has a valid instruction
// Signals (controller -> datapath):
//   fwd_rs1_sel, fwd_rs2_sel             : 0 regfile, 1 EX result, 2 MEM result
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//   ex_mem_stall, mem_wb_flush, pc_redirect, halted
//
// Optional macro PIPE_CTRL_PERF_EN adds the 64-bit counters
//   perf_stall_cyc, perf_flush_cnt, perf_lu_cnt (controller -> datapath).
interface pipe_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              id_rs1_r_ena;
    logic [ADDR_W-1:0] id_rs1_r_addr;
    logic              id_rs2_r_ena;
    logic [ADDR_W-1:0] id_rs2_r_addr;
    logic              ex_rd_w_ena;
    logic [ADDR_W-1:0] ex_rd_w_addr;
    logic              ex_mem_rd_ena;
    logic              ex_bj_taken;
    logic              ex_term;
    logic              mem_rd_w_ena;
    logic [ADDR_W-1:0] mem_rd_w_addr;
    logic              mem_req;
    logic              mem_ready;
    logic              if_ready;

    logic [1:0]        fwd_rs1_sel;
    logic [1:0]        fwd_rs2_sel;
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_stall;
    logic              id_ex_flush;
    logic              ex_mem_stall;
    logic              mem_wb_flush;
    logic              pc_redirect;
    logic              halted;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0]       perf_stall_cyc;
    logic [63:0]       perf_flush_cnt;
    logic [63:0]       perf_lu_cnt;
`endif

    modport master (
        input  id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
               ex_rd_w_ena, ex_rd_w_addr, ex_mem_rd_ena, ex_bj_taken, ex_term,
               mem_rd_w_ena, mem_rd_w_addr, mem_req, mem_ready, if_ready,
        output fwd_rs1_sel, fwd_rs2_sel, pc_stall, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
               pc_redirect, halted
`ifdef PIPE_CTRL_PERF_EN
        , output perf_stall_cyc, perf_flush_cnt, perf_lu_cnt
`endif
    );

    modport slave (
        output id_rs1_r_ena, id_rs1_r_addr, id_rs2_r_ena, id_rs2_r_addr,
               ex_rd_w_ena, ex_rd_w_addr, ex_mem_rd_ena, ex_bj_taken, ex_term,
               mem_rd_w_ena, mem_rd_w_addr, mem_req, mem_ready, if_ready,
        input  fwd_rs1_sel, fwd_rs2_sel, pc_stall, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush,
               pc_redirect, halted
`ifdef PIPE_CTRL_PERF_EN
        , input perf_stall_cyc, perf_flush_cnt, perf_lu_cnt
`endif
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage RV64I pipeline.
// Produces operand forwarding selects, load-use stalls, branch/jump flushes,
// data-memory wait freezes, and drains then halts the pipeline when the
// termination instruction reaches EX.
//
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous reset, active low (0 = reset); all outputs 0 while low
//   bus  - pipe_ctrl_if.master, all hazard inputs and pipeline controls
//
// Parameters:
//   DRAIN_CYCLES - cycles spent in DRAIN before halted asserts (>= 1)
//   ADDR_W       - register-file address width
//
// Optional macro PIPE_CTRL_PERF_EN adds 64-bit counters for stall cycles,
// redirects and load-use bubbles on the interface.
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int ADDR_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.master      bus
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] X0 = '0;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_q, lu_d;

    logic ex_hit_rs1, ex_hit_rs2, mem_hit_rs1, mem_hit_rs2;
    logic load_use, memwait;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, mem_wb_flush, pc_redirect, halted, lu_stall;

    // Address-match terms shared by forwarding and load-use detection.
    assign ex_hit_rs1  = bus.id_rs1_r_ena & bus.ex_rd_w_ena
                       & (bus.ex_rd_w_addr == bus.id_rs1_r_addr) & (bus.id_rs1_r_addr != X0);
    assign ex_hit_rs2  = bus.id_rs2_r_ena & bus.ex_rd_w_ena
                       & (bus.ex_rd_w_addr == bus.id_rs2_r_addr) & (bus.id_rs2_r_addr != X0);
    assign mem_hit_rs1 = bus.id_rs1_r_ena & bus.mem_rd_w_ena
                       & (bus.mem_rd_w_addr == bus.id_rs1_r_addr) & (bus.id_rs1_r_addr != X0);
    assign mem_hit_rs2 = bus.id_rs2_r_ena & bus.mem_rd_w_ena
                       & (bus.mem_rd_w_addr == bus.id_rs2_r_addr) & (bus.id_rs2_r_addr != X0);

    // A load in EX has no result yet, so it never forwards from EX.
    // lu_q stops the same dependency from bubbling twice in a row.
    assign load_use = bus.ex_mem_rd_ena & (ex_hit_rs1 | ex_hit_rs2) & ~lu_q;
    assign memwait  = bus.mem_req & ~bus.mem_ready;

    // Forwarding: EX beats MEM, and everything is forced to 0 in reset.
    always_comb begin
        bus.fwd_rs1_sel = 2'd0;
        bus.fwd_rs2_sel = 2'd0;
        if (rst) begin
            if (ex_hit_rs1 && !bus.ex_mem_rd_ena) bus.fwd_rs1_sel = 2'd1;
            else if (mem_hit_rs1)                 bus.fwd_rs1_sel = 2'd2;
            if (ex_hit_rs2 && !bus.ex_mem_rd_ena) bus.fwd_rs2_sel = 2'd1;
            else if (mem_hit_rs2)                 bus.fwd_rs2_sel = 2'd2;
        end
    end

    // State register, drain counter and load-use history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            lu_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lu_q    <= lu_d;
        end
    end

    // Next-state logic. A termination op seen on the memory-ready cycle of
    // MEM_WAIT still starts the drain; otherwise it would be lost.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lu_d    = lu_stall;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if ((state_q == RUN) ? memwait : !bus.mem_ready) begin
                    state_d = MEM_WAIT;
                end else if (bus.ex_bj_taken) begin
                    state_d = RUN;
                end else if (bus.ex_term) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!memwait) begin
                    if (cnt_q == '0) state_d = HALT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            HALT: state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    // Output decode per state; a frozen pipeline stalls everything up to
    // EX/MEM and bubbles MEM/WB so the pending access is not written twice.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        pc_redirect  = 1'b0;
        halted       = 1'b0;
        lu_stall     = 1'b0;
        if (rst) begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    if ((state_q == RUN) ? memwait : !bus.mem_ready) begin
                        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush} = '1;
                    end else if (bus.ex_bj_taken) begin
                        {pc_redirect, if_id_flush, id_ex_flush} = '1;
                    end else if (bus.ex_term) begin
                        {pc_stall, if_id_flush, id_ex_flush} = '1;
                    end else if (load_use) begin
                        {pc_stall, if_id_stall, id_ex_flush} = '1;
                        lu_stall = 1'b1;
                    end else if (!bus.if_ready) begin
                        {pc_stall, if_id_flush} = '1;
                    end
                end
                DRAIN: begin
                    if (memwait) begin
                        {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush} = '1;
                    end else begin
                        {pc_stall, if_id_flush, id_ex_flush} = '1;
                    end
                end
                HALT: begin
                    {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush} = '1;
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.pc_redirect  = pc_redirect;
    assign bus.halted       = halted;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] stall_cyc_q, flush_cnt_q, lu_cnt_q;

    // Performance counters; they hold their value once halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else if (state_q != HALT) begin
            if (pc_stall && (state_q == RUN || state_q == MEM_WAIT))
                stall_cyc_q <= stall_cyc_q + 64'd1;
            if (pc_redirect) flush_cnt_q <= flush_cnt_q + 64'd1;
            if (lu_stall)    lu_cnt_q    <= lu_cnt_q + 64'd1;
        end
    end

    assign bus.perf_stall_cyc = stall_cyc_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
    assign bus.perf_lu_cnt    = lu_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Each scenario task drives
// one cycle at a time, pushes the expected output vector onto a scoreboard
// queue, and pops/compares it when the outputs are sampled on the falling edge.
// Define PIPE_CTRL_PERF_EN to also exercise the performance counters.
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.ADDR_W(5)) bus ();

    pipe_ctrl #(.DRAIN_CYCLES(3), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control-vector order:
    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  ex_mem_stall, mem_wb_flush, pc_redirect, halted}
    localparam logic [8:0] NONE    = 9'b000000000;
    localparam logic [8:0] FREEZE  = 9'b110101100;
    localparam logic [8:0] HALTV   = 9'b110101101;
    localparam logic [8:0] LUV     = 9'b110010000;
    localparam logic [8:0] BJV     = 9'b001010010;
    localparam logic [8:0] TERMV   = 9'b101010000;
    localparam logic [8:0] NOFETCH = 9'b101000000;

    typedef struct {
        string      name;
        logic [12:0] vec;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   nCompared = 0;
    int   nMismatched = 0;

    function automatic logic [12:0] obs();
        return {bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.pc_stall, bus.if_id_stall,
                bus.if_id_flush, bus.id_ex_stall, bus.id_ex_flush, bus.ex_mem_stall,
                bus.mem_wb_flush, bus.pc_redirect, bus.halted};
    endfunction

    // Quiet pipeline: fetch valid, nothing in flight.
    task automatic idle();
        bus.id_rs1_r_ena  = 1'b0; bus.id_rs1_r_addr = '0;
        bus.id_rs2_r_ena  = 1'b0; bus.id_rs2_r_addr = '0;
        bus.ex_rd_w_ena   = 1'b0; bus.ex_rd_w_addr  = '0;
        bus.ex_mem_rd_ena = 1'b0; bus.ex_bj_taken   = 1'b0;
        bus.ex_term       = 1'b0;
        bus.mem_rd_w_ena  = 1'b0; bus.mem_rd_w_addr = '0;
        bus.mem_req       = 1'b0; bus.mem_ready     = 1'b0;
        bus.if_ready      = 1'b1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        idle();
        nextCycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            rst = (c == 2);
            if (c < 2) begin
                bus.ex_term = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd5;
                bus.id_rs1_r_ena = 1'b1; bus.id_rs1_r_addr = 5'd5;
                bus.mem_req = 1'b1;
            end
            sb.push_back('{$sformatf("reset c%0d", c), {2'd0, 2'd0, NONE}});
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_forward();
        for (int c = 0; c < 5; c++) begin
            idle();
            bus.id_rs1_r_ena = 1'b1; bus.id_rs2_r_ena = 1'b1;
            case (c)
                0: begin
                    bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd5;
                    bus.id_rs1_r_addr = 5'd5; bus.id_rs2_r_addr = 5'd5;
                    sb.push_back('{"fwd ex x5", {2'd1, 2'd1, NONE}});
                end
                1: begin
                    bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd0;
                    bus.mem_rd_w_ena = 1'b1; bus.mem_rd_w_addr = 5'd0;
                    sb.push_back('{"fwd x0", {2'd0, 2'd0, NONE}});
                end
                2: begin
                    bus.mem_rd_w_ena = 1'b1; bus.mem_rd_w_addr = 5'd9;
                    bus.id_rs1_r_addr = 5'd9; bus.id_rs2_r_addr = 5'd4;
                    sb.push_back('{"fwd mem x9", {2'd2, 2'd0, NONE}});
                end
                3: begin
                    bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd3;
                    bus.mem_rd_w_ena = 1'b1; bus.mem_rd_w_addr = 5'd3;
                    bus.id_rs1_r_addr = 5'd3; bus.id_rs2_r_addr = 5'd3;
                    sb.push_back('{"fwd ex over mem", {2'd1, 2'd1, NONE}});
                end
                default: begin
                    bus.id_rs1_r_ena = 1'b0;
                    bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd6;
                    bus.mem_rd_w_ena = 1'b1; bus.mem_rd_w_addr = 5'd6;
                    bus.id_rs1_r_addr = 5'd6; bus.id_rs2_r_addr = 5'd6;
                    sb.push_back('{"fwd rs1 disabled", {2'd0, 2'd1, NONE}});
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    bus.ex_mem_rd_ena = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd7;
                    bus.id_rs2_r_ena = 1'b1; bus.id_rs2_r_addr = 5'd7;
                    bus.id_rs1_r_ena = 1'b1; bus.id_rs1_r_addr = 5'd3;
                    sb.push_back('{"load-use rs2", {2'd0, 2'd0, LUV}});
                end
                1: begin
                    bus.mem_rd_w_ena = 1'b1; bus.mem_rd_w_addr = 5'd7;
                    bus.id_rs2_r_ena = 1'b1; bus.id_rs2_r_addr = 5'd7;
                    sb.push_back('{"load in mem", {2'd0, 2'd2, NONE}});
                end
                2: begin
                    bus.ex_mem_rd_ena = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd0;
                    bus.id_rs1_r_ena = 1'b1; bus.id_rs1_r_addr = 5'd0;
                    sb.push_back('{"load x0", {2'd0, 2'd0, NONE}});
                end
                3: begin
                    bus.ex_mem_rd_ena = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd7;
                    bus.id_rs1_r_ena = 1'b1; bus.id_rs1_r_addr = 5'd7;
                    sb.push_back('{"load-use rs1", {2'd0, 2'd0, LUV}});
                end
                default: sb.push_back('{"after load-use", {2'd0, 2'd0, NONE}});
            endcase
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_bj_priority();
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    bus.ex_bj_taken = 1'b1; bus.if_ready = 1'b0;
                    bus.ex_mem_rd_ena = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd7;
                    bus.id_rs2_r_ena = 1'b1; bus.id_rs2_r_addr = 5'd7;
                    sb.push_back('{"bj over lu/fetch", {2'd0, 2'd0, BJV}});
                end
                1: begin
                    bus.ex_bj_taken = 1'b1; bus.ex_term = 1'b1;
                    sb.push_back('{"bj over term", {2'd0, 2'd0, BJV}});
                end
                2: sb.push_back('{"bj then run", {2'd0, 2'd0, NONE}});
                default: begin
                    bus.if_ready = 1'b0;
                    sb.push_back('{"no fetch", {2'd0, 2'd0, NOFETCH}});
                end
            endcase
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_mem_wait();
        for (int c = 0; c < 7; c++) begin
            idle();
            if (c < 4) begin
                bus.mem_req = 1'b1; bus.ex_bj_taken = 1'b1;
                sb.push_back('{$sformatf("memwait c%0d", c), {2'd0, 2'd0, FREEZE}});
            end else if (c == 4) begin
                bus.mem_req = 1'b1; bus.mem_ready = 1'b1; bus.ex_bj_taken = 1'b1;
                sb.push_back('{"mem ready bj", {2'd0, 2'd0, BJV}});
            end else if (c == 5) begin
                bus.if_ready = 1'b0;
                sb.push_back('{"back in run", {2'd0, 2'd0, NOFETCH}});
            end else begin
                sb.push_back('{"run idle", {2'd0, 2'd0, NONE}});
            end
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_term();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (c == 0) begin
                bus.ex_term = 1'b1;
                sb.push_back('{"term in ex", {2'd0, 2'd0, TERMV}});
            end else if (c <= 3) begin
                sb.push_back('{$sformatf("drain c%0d", c), {2'd0, 2'd0, TERMV}});
            end else if (c == 4) begin
                sb.push_back('{"halted rises", {2'd0, 2'd0, HALTV}});
            end else if (c == 5) begin
                bus.ex_bj_taken = 1'b1; bus.if_ready = 1'b0;
                sb.push_back('{"halt sticky", {2'd0, 2'd0, HALTV}});
            end else if (c == 6) begin
                rst = 1'b0;
                sb.push_back('{"reset in halt", {2'd0, 2'd0, NONE}});
            end else begin
                rst = 1'b1;
                sb.push_back('{"run after halt", {2'd0, 2'd0, NONE}});
            end
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_drain_memwait();
        for (int c = 0; c < 6; c++) begin
            idle();
            case (c)
                0: begin
                    bus.ex_term = 1'b1;
                    sb.push_back('{"dm term", {2'd0, 2'd0, TERMV}});
                end
                2: begin
                    bus.mem_req = 1'b1;
                    sb.push_back('{"dm freeze", {2'd0, 2'd0, FREEZE}});
                end
                5:       sb.push_back('{"dm halted", {2'd0, 2'd0, HALTV}});
                default: sb.push_back('{$sformatf("dm drain c%0d", c), {2'd0, 2'd0, TERMV}});
            endcase
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
        pulseReset();
    endtask

    task automatic test_reset_mid_drain();
        for (int c = 0; c < 4; c++) begin
            idle();
            rst = (c != 2);
            case (c)
                0: begin
                    bus.ex_term = 1'b1;
                    sb.push_back('{"rd term", {2'd0, 2'd0, TERMV}});
                end
                1: sb.push_back('{"rd drain", {2'd0, 2'd0, TERMV}});
                2: sb.push_back('{"rd in reset", {2'd0, 2'd0, NONE}});
                default: sb.push_back('{"rd run", {2'd0, 2'd0, NONE}});
            endcase
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
    endtask

    task automatic test_perf();
        pulseReset();
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0 || c == 2) begin
                bus.ex_mem_rd_ena = 1'b1; bus.ex_rd_w_ena = 1'b1; bus.ex_rd_w_addr = 5'd8;
                bus.id_rs1_r_ena = 1'b1; bus.id_rs1_r_addr = 5'd8;
                sb.push_back('{$sformatf("perf lu c%0d", c), {2'd0, 2'd0, LUV}});
            end else if (c == 4) begin
                bus.ex_bj_taken = 1'b1;
                sb.push_back('{"perf bj", {2'd0, 2'd0, BJV}});
            end else begin
                sb.push_back('{$sformatf("perf idle c%0d", c), {2'd0, 2'd0, NONE}});
            end
            @(negedge clk);
            e = sb.pop_front(); nCompared++;
            if (obs() !== e.vec) begin
                nMismatched++;
                $display("[TB] FAIL %s: got %b, expected %b", e.name, obs(), e.vec);
            end
            nextCycle();
        end
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        nCompared++;
        if (bus.perf_lu_cnt !== 64'd2) begin
            nMismatched++;
            $display("[TB] FAIL perf_lu_cnt: got %0d, expected 2", bus.perf_lu_cnt);
        end
        nCompared++;
        if (bus.perf_flush_cnt !== 64'd1) begin
            nMismatched++;
            $display("[TB] FAIL perf_flush_cnt: got %0d, expected 1", bus.perf_flush_cnt);
        end
        nCompared++;
        if (bus.perf_stall_cyc !== 64'd2) begin
            nMismatched++;
            $display("[TB] FAIL perf_stall_cyc: got %0d, expected 2", bus.perf_stall_cyc);
        end
        nextCycle();
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_forward();
        test_load_use();
        test_bj_priority();
        test_mem_wait();
        test_term();
        test_drain_memwait();
        test_reset_mid_drain();
        test_perf();
        if (sb.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
